// File: rtl/nano_mem_slave.sv
// Memory-side responder for the nanoprocessor RAM bus: 254-byte store, timer and
// synchronized switches at the top two addresses, plus a byte-stream loader that holds the CPU.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | processor owns the bus; reads/writes serviced, loader stalled
// ST_LOAD | loader owns memory; cpu_hold/ld_ready high, CPU bus ignored
module nano_mem_slave #(
   parameter logic [15:0] TIMER_DIV = 16'd50000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ram_write,
   input  logic [7:0] ram_addr,
   input  logic [7:0] ram_data_write,
   output logic [7:0] ram_data_read,
   input  logic [7:0] sw,
   input  logic       ld_start,
   input  logic       ld_valid,
   input  logic [7:0] ld_data,
   input  logic       ld_last,
   output logic       ld_ready,
   output logic       cpu_hold,
   output logic       ld_full
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_LOAD = 1'b1;

   localparam logic [7:0] ADDR_TOP   = 8'hFD;
   localparam logic [7:0] ADDR_TIMER = 8'hFE;
   localparam logic [7:0] ADDR_SW    = 8'hFF;

   logic [0:0]  state_q, state_d;
   logic [7:0]  ptr_q, ptr_d;
   logic        full_q, full_d;
   logic [7:0]  timer_q, timer_d;
   logic [15:0] presc_q, presc_d;
   logic [7:0]  sw_s1_q, sw_s1_d;
   logic [7:0]  sw_s2_q, sw_s2_d;

   logic [7:0]  mem_q [0:253];
   logic        mem_we;
   logic [7:0]  mem_waddr;
   logic [7:0]  mem_wdata;
   logic        timer_clr;

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      full_d    = full_q;
      mem_we    = 1'b0;
      mem_waddr = ram_addr;
      mem_wdata = ram_data_write;
      timer_clr = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (ram_write) begin
               if (ram_addr <= ADDR_TOP) begin
                  mem_we = 1'b1;
               end else if (ram_addr == ADDR_TIMER) begin
                  timer_clr = 1'b1;
               end
            end
            if (ld_start) begin
               state_d = ST_LOAD;
               ptr_d   = 8'h00;
               full_d  = 1'b0;
            end
         end
         ST_LOAD: begin
            if (ld_valid) begin
               mem_we    = 1'b1;
               mem_waddr = ptr_q;
               mem_wdata = ld_data;
               ptr_d     = ptr_q + 8'h01;
               // the last storage byte ends the load whether or not ld_last is set
               if (ptr_q == ADDR_TOP) begin
                  full_d  = 1'b1;
                  state_d = ST_IDLE;
               end
               if (ld_last) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // a timer clear overrides a coincident prescaler wrap
   always_comb begin
      timer_d = timer_q;
      presc_d = presc_q + 16'd1;
      if (timer_clr) begin
         timer_d = 8'h00;
         presc_d = 16'd0;
      end else if (presc_q >= TIMER_DIV - 16'd1) begin
         timer_d = timer_q + 8'h01;
         presc_d = 16'd0;
      end
   end

   assign sw_s1_d = sw;
   assign sw_s2_d = sw_s1_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= 8'h00;
         full_q  <= 1'b0;
         timer_q <= 8'h00;
         presc_q <= 16'd0;
         sw_s1_q <= 8'h00;
         sw_s2_q <= 8'h00;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         full_q  <= full_d;
         timer_q <= timer_d;
         presc_q <= presc_d;
         sw_s1_q <= sw_s1_d;
         sw_s2_q <= sw_s2_d;
      end
   end

   // storage is deliberately left out of reset so a loaded image survives a CPU reset
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   always_comb begin
      ram_data_read = 8'h00;
      if (state_q == ST_IDLE) begin
         if (ram_addr == ADDR_SW) begin
            ram_data_read = sw_s2_q;
         end else if (ram_addr == ADDR_TIMER) begin
            ram_data_read = timer_q;
         end else begin
            ram_data_read = mem_q[ram_addr];
         end
      end
   end

   assign ld_ready = (state_q == ST_LOAD);
   assign cpu_hold = (state_q == ST_LOAD);
   assign ld_full  = full_q;

endmodule

// File: tb/tb_nano_mem_slave.sv
// Directed bench for nano_mem_slave with TIMER_DIV=4: vector table for IDLE
// read/write, plus sequences for loading, timer wrap, switches and reset.
module tb_nano_mem_slave;

   logic       clk;
   logic       reset_n;
   logic       ram_write;
   logic [7:0] ram_addr;
   logic [7:0] ram_data_write;
   logic [7:0] ram_data_read;
   logic [7:0] sw;
   logic       ld_start;
   logic       ld_valid;
   logic [7:0] ld_data;
   logic       ld_last;
   logic       ld_ready;
   logic       cpu_hold;
   logic       ld_full;

   int total;
   int bad;
   int cnt;
   int b;

   nano_mem_slave #(.TIMER_DIV(16'd4)) dut (
      .clk(clk), .reset_n(reset_n), .ram_write(ram_write), .ram_addr(ram_addr),
      .ram_data_write(ram_data_write), .ram_data_read(ram_data_read), .sw(sw),
      .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
      .ld_ready(ld_ready), .cpu_hold(cpu_hold), .ld_full(ld_full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // edges since last reset; timer model is ((cnt - b) / 4) mod 256
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) cnt <= 0;
      else          cnt <= cnt + 1;
   end

   function automatic logic [7:0] exp_timer();
      return 8'((cnt - b) / 4);
   endfunction

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   task automatic rd_chk(input string nm, input logic [7:0] addr, input logic [7:0] exp);
      @(negedge clk);
      ram_addr = addr;
      #1 chk(nm, ram_data_read, exp);
   endtask

   task automatic rd_timer(input string nm);
      @(negedge clk);
      ram_addr = 8'hFE;
      #1 chk(nm, ram_data_read, exp_timer());
   endtask

   task automatic start_load();
      @(negedge clk);
      ld_start = 1'b1;
      @(negedge clk);
      ld_start = 1'b0;
   endtask

   typedef struct {
      logic       wr;
      logic [7:0] addr;
      logic [7:0] wd;
      logic       ck;
      logic [7:0] exp;
   } vec_t;

   vec_t tbl [10];

   initial begin
      int hold_cnt;
      int acc;
      int late_ready;
      logic [7:0] v;

      tbl[0] = '{1'b1, 8'h40, 8'hA5, 1'b0, 8'h00};
      tbl[1] = '{1'b0, 8'h40, 8'h00, 1'b1, 8'hA5};
      tbl[2] = '{1'b1, 8'h41, 8'h5A, 1'b0, 8'h00};
      tbl[3] = '{1'b1, 8'h40, 8'h3C, 1'b1, 8'hA5};
      tbl[4] = '{1'b0, 8'h40, 8'h00, 1'b1, 8'h3C};
      tbl[5] = '{1'b0, 8'h41, 8'h00, 1'b1, 8'h5A};
      tbl[6] = '{1'b1, 8'h00, 8'hFF, 1'b0, 8'h00};
      tbl[7] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'hFF};
      tbl[8] = '{1'b1, 8'hFD, 8'h81, 1'b0, 8'h00};
      tbl[9] = '{1'b0, 8'hFD, 8'h00, 1'b1, 8'h81};

      total = 0; bad = 0; b = 0;
      reset_n = 1'b0; ram_write = 1'b0; ram_addr = 8'h00; ram_data_write = 8'h00;
      sw = 8'h00; ld_start = 1'b0; ld_valid = 1'b0; ld_data = 8'h00; ld_last = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      ram_addr = 8'hFE;
      #1;
      chk("rst_ready", {7'd0, ld_ready}, 8'h00);
      chk("rst_hold", {7'd0, cpu_hold}, 8'h00);
      chk("rst_full", {7'd0, ld_full}, 8'h00);
      chk("rst_timer", ram_data_read, 8'h00);

      // timer after n edges from reset is n/4
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         #1 chk("timer_step", ram_data_read, 8'(n / 4));
      end
      // write on the edge that would wrap the prescaler
      for (int i = 0; i < 4 && ((cnt - b) % 4) != 3; i++) @(negedge clk);
      ram_write = 1'b1; ram_addr = 8'hFE; ram_data_write = 8'h77;
      @(negedge clk);
      ram_write = 1'b0; b = cnt;
      #1 chk("timer_clr_wrap", ram_data_read, 8'h00);
      repeat (1020) @(negedge clk);
      #1 chk("timer_255", ram_data_read, 8'hFF);
      repeat (4) @(negedge clk);
      #1 chk("timer_wrap0", ram_data_read, 8'h00);

      // three-byte load with ld_last on the final byte
      start_load();
      hold_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         ld_valid = (i < 3);
         ld_data  = 8'(8'h10 * (i + 1));
         ld_last  = (i == 2);
         #1 if (cpu_hold) hold_cnt++;
         @(negedge clk);
      end
      chk("load3_hold_cycles", 8'(hold_cnt), 8'd3);
      chk("load3_full", {7'd0, ld_full}, 8'h00);
      rd_chk("load3_m0", 8'h00, 8'h10);
      rd_chk("load3_m1", 8'h01, 8'h20);
      rd_chk("load3_m2", 8'h02, 8'h30);

      // IDLE read/write vectors
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         ram_write = tbl[i].wr; ram_addr = tbl[i].addr; ram_data_write = tbl[i].wd;
         #1 if (tbl[i].ck) chk("vec_rd", ram_data_read, tbl[i].exp);
      end
      @(negedge clk);
      ram_write = 1'b1; ram_addr = 8'hFF; ram_data_write = 8'h99;
      @(negedge clk);
      ram_write = 1'b0;
      #1 chk("sw_write_ignored", ram_data_read, 8'h00);
      sw = 8'h3C;
      @(negedge clk);
      #1 chk("sw_one_edge", ram_data_read, 8'h00);
      @(negedge clk);
      #1 chk("sw_two_edges", ram_data_read, 8'h3C);

      // overflow load: 260 bytes offered, no ld_last
      start_load();
      acc = 0; late_ready = 0;
      for (int i = 0; i < 260; i++) begin
         ld_valid = 1'b1; ld_data = 8'(i * 3 + 1); ld_last = 1'b0;
         #1;
         if (acc >= 254 && ld_ready) late_ready++;
         if (ld_ready) acc++;
         @(negedge clk);
      end
      ld_valid = 1'b0;
      chk("full_accepted", 8'(acc), 8'd254);
      chk("full_late_ready", 8'(late_ready), 8'd0);
      chk("full_flag", {7'd0, ld_full}, 8'h01);
      rd_chk("full_m0", 8'h00, 8'h01);
      rd_chk("full_mfd", 8'hFD, 8'hF8);
      rd_timer("full_timer");

      // CPU write and second ld_start during LOAD
      start_load();
      chk("restart_clears_full", {7'd0, ld_full}, 8'h00);
      for (int i = 0; i < 7; i++) begin
         ld_valid = 1'b1; ld_data = 8'(8'hE0 + i); ld_last = (i == 6);
         ram_write = (i == 5); ram_addr = 8'h05; ram_data_write = 8'hEE; ld_start = (i == 5);
         #1 if (i == 5) chk("load_rd_zero", ram_data_read, 8'h00);
         @(negedge clk);
      end
      ld_valid = 1'b0; ld_last = 1'b0; ram_write = 1'b0; ld_start = 1'b0;
      #1 chk("load5_hold_done", {7'd0, cpu_hold}, 8'h00);
      rd_chk("load5_m5", 8'h05, 8'hE5);
      rd_chk("load5_m6", 8'h06, 8'hE6);
      rd_chk("load5_m0", 8'h00, 8'hE0);

      // reset in the middle of a load
      start_load();
      ld_valid = 1'b1; ld_data = 8'hC1;
      @(negedge clk);
      ld_data = 8'hC2;
      @(negedge clk);
      ld_valid = 1'b0;
      #2 reset_n = 1'b0;
      b = 0;
      #1;
      chk("rst_mid_hold", {7'd0, cpu_hold}, 8'h00);
      chk("rst_mid_ready", {7'd0, ld_ready}, 8'h00);
      chk("rst_mid_full", {7'd0, ld_full}, 8'h00);
      @(negedge clk);
      reset_n = 1'b1;
      rd_chk("rst_mid_m0", 8'h00, 8'hC1);
      rd_chk("rst_mid_m1", 8'h01, 8'hC2);
      rd_timer("rst_mid_timer");
      start_load();
      ld_valid = 1'b1; ld_data = 8'hD1; ld_last = 1'b1;
      @(negedge clk);
      ld_valid = 1'b0; ld_last = 1'b0;
      rd_chk("reload_m0", 8'h00, 8'hD1);
      rd_chk("reload_m1", 8'h01, 8'hC2);
      v = 8'h00;
      rd_chk("reload_sw", 8'hFF, 8'h3C | v);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
